// File: rtl/dm_pkg.sv
// Shared types and constants for the M-stage data memory.
package dm_pkg;

    localparam int unsigned DM_DEPTH = 4096;
    localparam int unsigned DM_AW    = 12;

    localparam logic [1:0] ALIGN_WORD = 2'b00;
    localparam logic [1:0] ALIGN_HALF = 2'b01;
    localparam logic [1:0] ALIGN_BYTE = 2'b10;
    localparam logic [1:0] ALIGN_RSVD = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dm_state_e;

    // Byte-lane write mask for a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] align, input logic [1:0] off);
        logic [3:0] m;
        m = 4'h0;
        case (align)
            ALIGN_WORD: m = 4'hF;
            ALIGN_HALF: m = off[1] ? 4'hC : 4'h3;
            ALIGN_BYTE: m = 4'(4'b0001 << off);
            default:    m = 4'h0;
        endcase
        return m;
    endfunction

    // Misalignment / reserved-size check (range is checked by the caller).
    function automatic logic align_err(input logic [1:0] align, input logic [1:0] off);
        logic e;
        e = 1'b0;
        case (align)
            ALIGN_WORD: e = (off != 2'b00);
            ALIGN_HALF: e = off[0];
            ALIGN_BYTE: e = 1'b0;
            default:    e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Combinational load extender: picks the addressed half/byte and sign/zero extends it.
module dm_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  align,
    input  logic        sign,
    output logic [31:0] data_c
);

    logic [15:0] half_c;
    logic [7:0]  byte_c;

    always_comb begin
        half_c = off[1] ? word[31:16] : word[15:0];
        byte_c = 8'h00;
        case (off)
            2'd0:    byte_c = word[7:0];
            2'd1:    byte_c = word[15:8];
            2'd2:    byte_c = word[23:16];
            default: byte_c = word[31:24];
        endcase
    end

    always_comb begin
        data_c = 32'h0;
        case (align)
            ALIGN_WORD: data_c = word;
            ALIGN_HALF: data_c = {{16{sign & half_c[15]}}, half_c};
            ALIGN_BYTE: data_c = {{24{sign & byte_c[7]}}, byte_c};
            default:    data_c = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_dmem_stage.sv
// Memory stage: word-organised data memory with lane-merged stores, registered
// extended loads for W, and a post-reset clear sequence that zeroes the array.
module m_dmem_stage
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned AW    = DM_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] M_ALURes,
    input  logic [31:0] M_RT,
    input  logic        M_DM_WE,
    input  logic [1:0]  M_DM_Align,
    input  logic        M_DM_Sign,
    output logic [31:0] W_DM_RD,
    output logic        W_DM_Err,
    output logic        busy
);

    logic [31:0] mem [DEPTH];

    dm_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic        clr_we_c;
    logic        run_c;

    logic [AW-1:0] idx_c;
    logic [1:0]    off_c;
    logic          oor_c;
    logic          err_c;
    logic          st_en_c;
    logic [3:0]    lane_we_c;
    logic [31:0]   rd_word_c;
    logic [31:0]   wdata_c;
    logic [31:0]   wmerge_c;
    logic [31:0]   ext_c;

    // Clear FSM state register; busy mirrors the next state so it is a true flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == CLEAR);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        clr_we_c = 1'b0;
        run_c    = 1'b0;
        case (state_q)
            CLEAR:   clr_we_c = 1'b1;
            default: run_c    = 1'b1;
        endcase
    end

    // Address decode and access error.
    always_comb begin
        idx_c = M_ALURes[AW+1:2];
        off_c = M_ALURes[1:0];
        oor_c = |M_ALURes[31:AW+2];
        err_c = oor_c | align_err(M_DM_Align, off_c);
    end

    assign rd_word_c = mem[idx_c];

    // Store data is replicated across lanes so the lane mask alone picks the target.
    always_comb begin
        wdata_c = M_RT;
        case (M_DM_Align)
            ALIGN_HALF: wdata_c = {2{M_RT[15:0]}};
            ALIGN_BYTE: wdata_c = {4{M_RT[7:0]}};
            default:    wdata_c = M_RT;
        endcase
        lane_we_c = lane_mask(M_DM_Align, off_c);
        for (int i = 0; i < 4; i++) begin
            wmerge_c[8*i +: 8] = lane_we_c[i] ? wdata_c[8*i +: 8] : rd_word_c[8*i +: 8];
        end
        st_en_c = run_c & WE & M_DM_WE & ~err_c;
    end

    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[cnt_q] <= 32'h0;
        end else if (st_en_c) begin
            mem[idx_c] <= wmerge_c;
        end
    end

    dm_ext u_ext (
        .word   (rd_word_c),
        .off    (off_c),
        .align  (M_DM_Align),
        .sign   (M_DM_Sign),
        .data_c (ext_c)
    );

    // W-stage load register; reads the pre-store word of this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            W_DM_RD  <= 32'h0;
            W_DM_Err <= 1'b0;
        end else if (run_c && WE) begin
            W_DM_Err <= err_c;
            W_DM_RD  <= err_c ? 32'h0 : ext_c;
        end
    end

endmodule

// File: tb/tb_m_dmem_stage.sv
// Scoreboard bench for m_dmem_stage: stimulus queues expected W results, a monitor checks them.
module tb_m_dmem_stage;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        WE;
    logic [31:0] M_ALURes;
    logic [31:0] M_RT;
    logic        M_DM_WE;
    logic [1:0]  M_DM_Align;
    logic        M_DM_Sign;
    logic [31:0] W_DM_RD;
    logic        W_DM_Err;
    logic        busy;

    m_dmem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .WE         (WE),
        .M_ALURes   (M_ALURes),
        .M_RT       (M_RT),
        .M_DM_WE    (M_DM_WE),
        .M_DM_Align (M_DM_Align),
        .M_DM_Sign  (M_DM_Sign),
        .W_DM_RD    (W_DM_RD),
        .W_DM_Err   (W_DM_Err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic resp_valid;

    // W outputs update on an edge where WE=1 and the clear has finished.
    always @(posedge clk or negedge rst) begin
        if (!rst) resp_valid <= 1'b0;
        else      resp_valid <= WE && !busy;
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got rd=%h err=%b, no response expected", W_DM_RD, W_DM_Err);
            end else begin
                e_mon = exp_q.pop_front();
                if (W_DM_Err !== e_mon.err || (e_mon.chk_rd && W_DM_RD !== e_mon.rd)) begin
                    n_bad++;
                    $display("FAIL %s: got rd=%h err=%b, expected rd=%h err=%b",
                             e_mon.name, W_DM_RD, W_DM_Err, e_mon.rd, e_mon.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic acc(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic dwe, input logic [1:0] al, input logic sg,
                       input logic [31:0] erd, input logic eerr, input logic crd);
        exp_t e;
        @(negedge clk);
        WE = 1'b1; M_ALURes = a; M_RT = d; M_DM_WE = dwe; M_DM_Align = al; M_DM_Sign = sg;
        e.rd = erd; e.err = eerr; e.chk_rd = crd; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle_drain(input string nm);
        @(negedge clk);
        WE = 1'b0; M_DM_WE = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d pending, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Counts rising edges from reset release until busy drops (bounded).
    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 5000);
        chk({nm, "_clear_cycles"}, 32'(n), 32'd4096);
    endtask

    task automatic async_reset(input string nm);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk({nm, "_rst_rd"},   W_DM_RD, 32'h0);
        chk({nm, "_rst_err"},  32'(W_DM_Err), 32'h0);
        chk({nm, "_rst_busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        rst = 1'b0; WE = 1'b0; M_ALURes = '0; M_RT = '0; M_DM_WE = 1'b0;
        M_DM_Align = ALIGN_WORD; M_DM_Sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd",   W_DM_RD, 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);

        // 1: clear with a store request held at address 0 throughout
        @(negedge clk);
        WE = 1'b1; M_DM_WE = 1'b1; M_ALURes = 32'h0; M_RT = 32'hFFFF_FFFF;
        rst = 1'b1;
        wait_clear("t1");
        WE = 1'b0; M_DM_WE = 1'b0;
        chk("t1_rd_held",  W_DM_RD, 32'h0);
        chk("t1_err_held", 32'(W_DM_Err), 32'h0);
        acc("t1_load_3ffc", 32'h3FFC, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
        acc("t1_load_0",    32'h0000, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);

        // 2: stores of every width then loads
        acc("t2_st_word", 32'h10, 32'h1234_5678, 1'b1, ALIGN_WORD, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        acc("t2_st_byte", 32'h11, 32'h0000_00AB, 1'b1, ALIGN_BYTE, 1'b0, 32'h0000_0056, 1'b0, 1'b1);
        acc("t2_st_half", 32'h12, 32'h0000_8001, 1'b1, ALIGN_HALF, 1'b0, 32'h0000_1234, 1'b0, 1'b1);
        acc("t2_ld_word", 32'h10, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h8001_AB78, 1'b0, 1'b1);
        acc("t2_ld_sb11", 32'h11, 32'h0, 1'b0, ALIGN_BYTE, 1'b1, 32'hFFFF_FFAB, 1'b0, 1'b1);
        acc("t2_ld_ub11", 32'h11, 32'h0, 1'b0, ALIGN_BYTE, 1'b0, 32'h0000_00AB, 1'b0, 1'b1);
        acc("t2_ld_sh12", 32'h12, 32'h0, 1'b0, ALIGN_HALF, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);
        acc("t2_ld_sb10", 32'h10, 32'h0, 1'b0, ALIGN_BYTE, 1'b1, 32'h0000_0078, 1'b0, 1'b1);
        acc("t2_ld_uh10", 32'h10, 32'h0, 1'b0, ALIGN_HALF, 1'b0, 32'h0000_AB78, 1'b0, 1'b1);
        acc("t2_ld_sb13", 32'h13, 32'h0, 1'b0, ALIGN_BYTE, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);

        // 3: misalignment, range, reserved size
        acc("t3_st_mis",  32'h22, 32'hDEAD_BEEF, 1'b1, ALIGN_WORD, 1'b0, 32'h0, 1'b1, 1'b1);
        acc("t3_ld_20",   32'h20, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
        acc("t3_ld_h13",  32'h13, 32'h0, 1'b0, ALIGN_HALF, 1'b1, 32'h0, 1'b1, 1'b1);
        acc("t3_ld_oor",  32'h4000, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b1, 1'b1);
        acc("t3_rsvd",    32'h10, 32'h0, 1'b0, ALIGN_RSVD, 1'b0, 32'h0, 1'b1, 1'b1);
        acc("t3_st_oorb", 32'h4011, 32'h0000_00FF, 1'b1, ALIGN_BYTE, 1'b0, 32'h0, 1'b1, 1'b1);
        acc("t3_ld_10",   32'h10, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h8001_AB78, 1'b0, 1'b1);

        // 4: stall holds W and blocks the store
        acc("t4_ld_10", 32'h10, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h8001_AB78, 1'b0, 1'b1);
        @(negedge clk);
        WE = 1'b0; M_DM_WE = 1'b1; M_RT = 32'h0; M_ALURes = 32'h10; M_DM_Align = ALIGN_WORD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_stall_rd",  W_DM_RD, 32'h8001_AB78);
            chk("t4_stall_err", 32'(W_DM_Err), 32'h0);
        end
        acc("t4_ld_after", 32'h10, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h8001_AB78, 1'b0, 1'b1);

        // 5: reset during RUN, then again mid-clear
        acc("t5_st_top", 32'h3FFC, 32'h0BAD_F00D, 1'b1, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
        acc("t5_ld_top", 32'h3FFC, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
        idle_drain("t5a");
        chk("t5_pre_rd", W_DM_RD, 32'h0BAD_F00D);
        async_reset("t5_run");
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("t5_mid_busy", 32'(busy), 32'h1);
        async_reset("t5_clr");
        @(negedge clk);
        rst = 1'b1;
        wait_clear("t5");
        acc("t5_ld_10",  32'h10, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
        acc("t5_ld_h12", 32'h12, 32'h0, 1'b0, ALIGN_HALF, 1'b1, 32'h0, 1'b0, 1'b1);
        acc("t5_ld_top2", 32'h3FFC, 32'h0, 1'b0, ALIGN_WORD, 1'b0, 32'h0, 1'b0, 1'b1);
        idle_drain("t5b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_dmem_stage.md
Name: m_dmem_stage

Overview:
- Memory-stage consumer of the E/M pipeline register fields (address, store data, DM write enable, alignment, sign).
- Holds the word-organised data memory and performs byte, half and word stores with lane merge.
- Loads are synchronous; extended load data is registered for the W stage.
- After reset, a clear FSM zeroes the array before accesses are accepted.

Parameters:
DEPTH, 4096, number of 32-bit words in the data memory (power of two).
AW, 12, word-index width; equals log2(DEPTH).

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  reset; asynchronous, active-low.
WE  in  1  pipeline advance enable from the hazard unit; 0 means stall.
M_ALURes  in  32  byte address.
M_RT  in  32  store data.
M_DM_WE  in  1  store request.
M_DM_Align  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
M_DM_Sign  in  1  1 = sign-extend load, 0 = zero-extend.
W_DM_RD  out  32  extended load data for the W stage (registered).
W_DM_Err  out  1  registered flag: previous access was misaligned, out of range or reserved size.
busy  out  1  high while the clear FSM runs; the hazard unit stalls on it.

Behaviour:
- Reset assertion, asynchronous:
  - FSM enters CLEAR; clear counter resets to 0.
  - busy goes to 1.
  - W_DM_RD and W_DM_Err go to 0.
- Reset asserted mid-clear restarts the clear from index 0.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - When cnt equals DEPTH-1, that word is written and the FSM moves to RUN on the same edge.
  - busy is 0 from the first RUN cycle, so clearing takes exactly DEPTH cycles after reset release.
  - All inputs are ignored; no store occurs; W outputs hold 0.
- RUN state is terminal until the next reset.
- Word index and offset:
  - idx = M_ALURes[AW+1:2]; off = M_ALURes[1:0].
  - The access is out of range when M_ALURes[31:AW+2] is nonzero.
- Error condition (err):
  - Word access with off != 0.
  - Half access with off[0] = 1.
  - Align = 11.
  - Out-of-range address.
- Store (RUN, WE=1, M_DM_WE=1, err=0), on the rising edge:
  - Word: mem[idx] takes M_RT.
  - Half: byte lanes 2*off[1] and 2*off[1]+1 take M_RT[15:0]; other lanes are unchanged.
  - Byte: lane off takes M_RT[7:0]; other lanes are unchanged.
  - Lane 0 is bits 7:0 (little-endian).
- Store with err=1: memory is unchanged.
- Load path, every RUN edge with WE=1:
  - W_DM_RD = ext(mem[idx], off, Align, Sign) sampled before any same-edge write.
  - W_DM_Err = err.
  - If err=1, W_DM_RD = 0.
  - The load happens regardless of M_DM_WE; W selects the data only for load instructions.
- ext rules:
  - Word: returns the word unchanged.
  - Half: selects bits 16*off[1]+15 down to 16*off[1]; extends bit 15 if Sign, else zeros.
  - Byte: selects lane off; extends bit 7 if Sign, else zeros.
- WE=0 in RUN: no store; W_DM_RD and W_DM_Err hold.
- Latency: a load in M on edge n has W_DM_RD valid from edge n until edge n+1.
- Store then load to the same word on consecutive instructions: the load sees the stored value, because the store is committed on the earlier edge.
- Never simultaneous: only one instruction occupies M, so no store and load for different instructions share an edge.

Decomposition:
- Package dm_pkg:
  - Align encodings ALIGN_WORD=2'b00, ALIGN_HALF=2'b01, ALIGN_BYTE=2'b10, ALIGN_RSVD=2'b11.
  - FSM state type {CLEAR, RUN}.
  - Default DEPTH.
- Sub-module dm_ext: combinational load extender (word, off, align, sign -> 32-bit data).
- Store lane merge stays inline.

Test Plan:
1. Reset release, clear: release rst with WE=1, M_DM_WE=1 at addr 0x0 throughout -> busy stays 1 for exactly 4096 cycles; after clear, a load from 0x3FFC returns 0x00000000; the word at 0x0 was never written during CLEAR.
2. Store and load, all widths:
   - Store word 0x12345678 at 0x10, then store byte 0xAB at 0x11, then store half 0x8001 at 0x12.
   - Word load at 0x10 -> 0x8001AB78.
   - Signed byte load at 0x11 -> 0xFFFFFFAB; unsigned byte load at 0x11 -> 0x000000AB.
   - Signed half load at 0x12 -> 0xFFFF8001.
3. Misalignment and range:
   - Word store 0xDEADBEEF at 0x22 -> W_DM_Err=1 and word 0x20 unchanged.
   - Half load at 0x13 -> W_DM_Err=1, W_DM_RD=0.
   - Load at 0x00004000 -> W_DM_Err=1.
   - Align=11 -> W_DM_Err=1.
4. Stall: a load at 0x10 yields 0x8001AB78; then hold WE=0 for 3 cycles with M_DM_WE=1 and store data 0 at 0x10 -> W_DM_RD holds 0x8001AB78 and memory is unchanged.
5. Mid-operation reset: assert rst during RUN after writes, then again 100 cycles into CLEAR -> outputs go to 0 asynchronously; clear restarts; busy stays high 4096 cycles from the last release; all earlier data reads back 0.
